// File: rtl/adpcm_pkg.sv
// Shared constants and helpers for the IMA ADPCM encoder controller:
// step/index tables, FSM state encoding, saturation and clamp functions.
package adpcm_pkg;

  localparam logic [6:0] IDX_MAX = 7'd88;

  localparam logic [15:0] STEP_TBL [0:88] = '{
    16'd7,     16'd8,     16'd9,     16'd10,    16'd11,    16'd12,    16'd13,    16'd14,
    16'd16,    16'd17,    16'd19,    16'd21,    16'd23,    16'd25,    16'd28,    16'd31,
    16'd34,    16'd37,    16'd41,    16'd45,    16'd50,    16'd55,    16'd60,    16'd66,
    16'd73,    16'd80,    16'd88,    16'd97,    16'd107,   16'd118,   16'd130,   16'd143,
    16'd157,   16'd173,   16'd190,   16'd209,   16'd230,   16'd253,   16'd279,   16'd307,
    16'd337,   16'd371,   16'd408,   16'd449,   16'd494,   16'd544,   16'd598,   16'd658,
    16'd724,   16'd796,   16'd876,   16'd963,   16'd1060,  16'd1166,  16'd1282,  16'd1411,
    16'd1552,  16'd1707,  16'd1878,  16'd2066,  16'd2272,  16'd2499,  16'd2749,  16'd3024,
    16'd3327,  16'd3660,  16'd4026,  16'd4428,  16'd4871,  16'd5358,  16'd5894,  16'd6484,
    16'd7132,  16'd7845,  16'd8630,  16'd9493,  16'd10442, 16'd11487, 16'd12635, 16'd13899,
    16'd15289, 16'd16818, 16'd18500, 16'd20350, 16'd22385, 16'd24623, 16'd27086, 16'd29794,
    16'd32767
  };

  localparam logic signed [4:0] IDX_TBL [0:7] = '{
    -5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd2, 5'sd4, 5'sd6, 5'sd8
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_QUANT  = 2'd1,
    ST_UPDATE = 2'd2,
    ST_EMIT   = 2'd3
  } state_e;

  function automatic logic [15:0] sat16(input logic signed [17:0] v);
    if (v > 18'sd32767) begin
      return 16'h7FFF;
    end else if (v < -18'sd32768) begin
      return 16'h8000;
    end else begin
      return v[15:0];
    end
  endfunction

  function automatic logic [6:0] clamp_index(input logic signed [8:0] v);
    if (v < 9'sd0) begin
      return 7'd0;
    end else if (v > 9'sd88) begin
      return IDX_MAX;
    end else begin
      return v[6:0];
    end
  endfunction

endpackage

// File: rtl/adpcm_enc_ctrl_if.sv
// Sample, sync and code handshake bundle of the ADPCM encoder controller.
interface adpcm_enc_ctrl_if;
  logic        in_valid;
  logic [15:0] in_sample;
  logic        in_ready;
  logic        sync_valid;
  logic [15:0] sync_pred;
  logic [6:0]  sync_index;
  logic        out_valid;
  logic [3:0]  out_code;
  logic        out_ready;
  logic [15:0] pred_out;
  logic [6:0]  index_out;

  modport master (
    output in_valid, in_sample, sync_valid, sync_pred, sync_index, out_ready,
    input  in_ready, out_valid, out_code, pred_out, index_out
  );

  modport slave (
    input  in_valid, in_sample, sync_valid, sync_pred, sync_index, out_ready,
    output in_ready, out_valid, out_code, pred_out, index_out
  );
endinterface

// File: rtl/adpcm_enc_ctrl_quantizer.sv
// IMA 4-bit quantizer: sign of (sample - pred) plus three successive
// magnitude decisions against step, step/2 and step/4.
module quantizer (
  input  logic [15:0] sample,
  input  logic [15:0] pred,
  input  logic [15:0] step,
  output logic [3:0]  code
);

  logic [16:0] diff_s;
  logic [16:0] mag_s;
  logic [16:0] step_s;
  logic [16:0] rem1_s;
  logic [16:0] rem2_s;
  logic        b2_s;
  logic        b1_s;
  logic        b0_s;

  // Successive-approximation magnitude decisions
  always_comb begin
    diff_s = {sample[15], sample} - {pred[15], pred};
    mag_s  = diff_s[16] ? (17'd0 - diff_s) : diff_s;
    step_s = {1'b0, step};
    if (mag_s >= step_s) begin
      b2_s   = 1'b1;
      rem1_s = mag_s - step_s;
    end else begin
      b2_s   = 1'b0;
      rem1_s = mag_s;
    end
    if (rem1_s >= (step_s >> 1)) begin
      b1_s   = 1'b1;
      rem2_s = rem1_s - (step_s >> 1);
    end else begin
      b1_s   = 1'b0;
      rem2_s = rem1_s;
    end
    b0_s = (rem2_s >= (step_s >> 2));
    code = {diff_s[16], b2_s, b1_s, b0_s};
  end

endmodule

// File: rtl/adpcm_enc_ctrl.sv
// ADPCM encoder sequencer: accepts a PCM sample, quantizes it against the
// predictor, updates predictor/step index and offers the 4-bit code.
module adpcm_enc_ctrl
  import adpcm_pkg::*;
(
  input logic             clk,
  input logic             rst,
  adpcm_enc_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_QUANT  = ST_QUANT;
  localparam logic [1:0] S_UPDATE = ST_UPDATE;
  localparam logic [1:0] S_EMIT   = ST_EMIT;

  logic [1:0]         state_r;
  logic [15:0]        sample_r;
  logic [15:0]        pred_r;
  logic [6:0]         index_r;
  logic [3:0]         code_r;

  logic [15:0]        step_s;
  logic [16:0]        step17_s;
  logic [16:0]        dq_s;
  logic signed [17:0] pred_sum_s;
  logic signed [8:0]  idx_sum_s;
  logic [15:0]        pred_next_s;
  logic [6:0]         index_next_s;
  logic [6:0]         sync_index_s;
  logic [3:0]         q_code_s;

  quantizer u_quantizer (
    .sample (sample_r),
    .pred   (pred_r),
    .step   (step_s),
    .code   (q_code_s)
  );

  // Reconstruction of the predictor and step-index adaptation from code_r
  always_comb begin
    if (index_r > IDX_MAX) begin
      step_s = STEP_TBL[IDX_MAX];
    end else begin
      step_s = STEP_TBL[index_r];
    end
    step17_s = {1'b0, step_s};
    dq_s = (step17_s >> 3)
         + (code_r[2] ? step17_s        : 17'd0)
         + (code_r[1] ? (step17_s >> 1) : 17'd0)
         + (code_r[0] ? (step17_s >> 2) : 17'd0);
    if (code_r[3]) begin
      pred_sum_s = $signed({{2{pred_r[15]}}, pred_r}) - $signed({1'b0, dq_s});
    end else begin
      pred_sum_s = $signed({{2{pred_r[15]}}, pred_r}) + $signed({1'b0, dq_s});
    end
    pred_next_s  = sat16(pred_sum_s);
    idx_sum_s    = $signed({2'b00, index_r})
                 + $signed({{4{IDX_TBL[code_r[2:0]][4]}}, IDX_TBL[code_r[2:0]]});
    index_next_s = clamp_index(idx_sum_s);
    sync_index_s = clamp_index($signed({2'b00, bus.sync_index}));
  end

  // Sequencer state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= S_IDLE;
      sample_r <= 16'h0000;
      pred_r   <= 16'h0000;
      index_r  <= 7'd0;
      code_r   <= 4'h0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.sync_valid) begin
            pred_r  <= bus.sync_pred;
            index_r <= sync_index_s;
          end else if (bus.in_valid) begin
            sample_r <= bus.in_sample;
            state_r  <= S_QUANT;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_QUANT: begin
          code_r  <= q_code_s;
          state_r <= S_UPDATE;
        end
        S_UPDATE: begin
          pred_r  <= pred_next_s;
          index_r <= index_next_s;
          state_r <= S_EMIT;
        end
        S_EMIT: begin
          if (bus.out_ready) begin
            state_r <= S_IDLE;
          end else begin
            state_r <= S_EMIT;
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  // Handshake flags decode from state only; sync_valid alone may gate in_ready
  assign bus.in_ready  = (state_r == S_IDLE) && !bus.sync_valid;
  assign bus.out_valid = (state_r == S_EMIT);
  assign bus.out_code  = code_r;
  assign bus.pred_out  = pred_r;
  assign bus.index_out = index_r;

endmodule

// File: tb/tb_adpcm_enc_ctrl.sv
// Randomized self-checking bench for adpcm_enc_ctrl against an
// integer-arithmetic IMA ADPCM encoder reference model.
module tb_adpcm_enc_ctrl;
  import adpcm_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adpcm_enc_ctrl_if bus ();

  adpcm_enc_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  int m_pred;
  int m_idx;
  int idx_adj [8] = '{-1, -1, -1, -1, 2, 4, 6, 8};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference encoder step: integer arithmetic straight from the IMA rules
  function automatic logic [3:0] model_step(input int s);
    int st, diff, mag, dq;
    logic [3:0] c;
    st   = int'(STEP_TBL[m_idx]);
    diff = s - m_pred;
    c    = 4'h0;
    c[3] = (diff < 0);
    mag  = (diff < 0) ? -diff : diff;
    if (mag >= st)     begin c[2] = 1'b1; mag = mag - st;     end
    if (mag >= st / 2) begin c[1] = 1'b1; mag = mag - st / 2; end
    if (mag >= st / 4) begin c[0] = 1'b1; end
    dq = st / 8 + (c[2] ? st : 0) + (c[1] ? st / 2 : 0) + (c[0] ? st / 4 : 0);
    m_pred = c[3] ? m_pred - dq : m_pred + dq;
    if (m_pred > 32767)  m_pred = 32767;
    if (m_pred < -32768) m_pred = -32768;
    m_idx = m_idx + idx_adj[c[2:0]];
    if (m_idx < 0)  m_idx = 0;
    if (m_idx > 88) m_idx = 88;
    return c;
  endfunction

  function automatic logic [31:0] pred16(input int p);
    logic [15:0] v;
    v = p[15:0];
    return {16'h0000, v};
  endfunction

  task automatic check_state(input string tag);
    check_eq({tag, "_pred"}, {16'h0000, bus.pred_out}, pred16(m_pred));
    check_eq({tag, "_idx"}, {25'd0, bus.index_out}, m_idx);
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_sample = 16'h0000;
    bus.sync_valid = 1'b0; bus.sync_pred = 16'h0000; bus.sync_index = 7'd0;
    bus.out_ready = 1'b0;
    tick; tick;
    m_pred = 0; m_idx = 0;
    check_eq("rst_in_ready", {31'd0, bus.in_ready}, 1);
    check_eq("rst_out_valid", {31'd0, bus.out_valid}, 0);
    check_eq("rst_out_code", {28'd0, bus.out_code}, 0);
    check_state("rst");
    rst = 1'b0;
    tick;
  endtask

  task automatic do_sync(input logic [15:0] p, input logic [6:0] idx);
    bus.sync_valid = 1'b1; bus.sync_pred = p; bus.sync_index = idx;
    bus.in_valid = 1'b1; bus.in_sample = 16'h1234;
    #1;
    check_eq("sync_in_ready_low", {31'd0, bus.in_ready}, 0);
    tick;
    bus.sync_valid = 1'b0; bus.in_valid = 1'b0;
    #1;
    m_pred = int'($signed(p));
    m_idx  = (idx > 7'd88) ? 88 : int'(idx);
    check_state("sync");
    check_eq("sync_no_accept", {31'd0, bus.in_ready}, 1);
    check_eq("sync_no_valid", {31'd0, bus.out_valid}, 0);
  endtask

  task automatic send_sample(input logic [15:0] s, input int stall, output logic [3:0] code_seen);
    int n;
    logic [3:0] exp_c;
    bus.in_sample = s; bus.in_valid = 1'b1;
    #1;
    n = 0;
    while (!bus.in_ready && n < 20) begin tick; n++; end
    check_eq("accept_wait", {31'd0, (n < 20)}, 1);
    tick;
    bus.in_valid = 1'b0; bus.in_sample = 16'($urandom);
    n = 1;
    while (!bus.out_valid && n < 10) begin tick; n++; end
    check_eq("latency", n, 3);
    exp_c = model_step(int'($signed(s)));
    code_seen = bus.out_code;
    check_eq("code", {28'd0, bus.out_code}, {28'd0, exp_c});
    check_state("upd");
    for (int i = 0; i < stall; i++) begin
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.in_sample = 16'($urandom);
      bus.sync_valid = 1'($urandom_range(0, 1));
      bus.sync_pred = 16'($urandom); bus.sync_index = 7'($urandom);
      tick;
      check_eq("bp_valid", {31'd0, bus.out_valid}, 1);
      check_eq("bp_code", {28'd0, bus.out_code}, {28'd0, exp_c});
      check_eq("bp_in_ready", {31'd0, bus.in_ready}, 0);
      check_state("bp");
    end
    bus.in_valid = 1'b0; bus.sync_valid = 1'b0; bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    check_eq("post_valid", {31'd0, bus.out_valid}, 0);
    check_eq("post_in_ready", {31'd0, bus.in_ready}, 1);
    check_state("post");
  endtask

  task automatic reset_in_update;
    int seen;
    bus.in_sample = 16'h4000; bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    tick;
    rst = 1'b1;
    #1;
    m_pred = 0; m_idx = 0;
    check_eq("mid_rst_valid", {31'd0, bus.out_valid}, 0);
    check_eq("mid_rst_code", {28'd0, bus.out_code}, 0);
    check_eq("mid_rst_in_ready", {31'd0, bus.in_ready}, 1);
    check_state("mid_rst");
    tick;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (bus.out_valid) seen++;
    end
    bus.out_ready = 1'b0;
    check_eq("mid_rst_no_emit", seen, 0);
  endtask

  initial begin
    logic [3:0] c;
    int s;

    apply_reset;
    send_sample(16'h0100, 0, c);
    check_eq("pos_code", {28'd0, c}, 32'h7);
    check_eq("pos_pred", {16'h0000, bus.pred_out}, 32'h000B);
    check_eq("pos_idx", {25'd0, bus.index_out}, 8);

    apply_reset;
    send_sample(16'hFF00, 0, c);
    check_eq("neg_code", {28'd0, c}, 32'hF);
    check_eq("neg_pred", {16'h0000, bus.pred_out}, 32'hFFF5);
    check_eq("neg_idx", {25'd0, bus.index_out}, 8);

    do_sync(16'h7F00, 7'd88);
    send_sample(16'h7FFF, 0, c);
    check_eq("sat_code", {28'd0, c}, 32'h0);
    check_eq("sat_pred", {16'h0000, bus.pred_out}, 32'h7FFF);
    check_eq("sat_idx", {25'd0, bus.index_out}, 87);

    apply_reset;
    send_sample(16'h0000, 0, c);
    check_eq("clamp_idx", {25'd0, bus.index_out}, 0);

    send_sample(16'h0200, 5, c);
    do_sync(16'h8123, 7'd120);
    reset_in_update;

    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        do_sync(16'($urandom), 7'($urandom));
      end
      case ($urandom_range(0, 2))
        0:       s = int'($signed(16'($urandom)));
        1:       s = m_pred + int'($urandom_range(0, 512)) - 256;
        default: s = m_pred + int'($urandom_range(0, 16384)) - 8192;
      endcase
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
      send_sample(s[15:0], int'($urandom_range(0, 3)), c);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
